// File: rtl/fp_mul_sched_pkg.sv
// Shared types and constants for the floating-point multiplier scheduler.
package fp_mul_pkg;

  // Scheduler sequence around the shared multiplier.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // IEEE-754 single-precision special values.
  localparam logic [31:0] QNAN    = 32'hFFFF_FFFF;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  // Width of a down-counter that has to hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp_mul_sched_if.sv
// Client request/response bus plus the multiplier control bus of the scheduler.
interface fp_mul_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ-1:0]       o_req_ready;
  logic [N_REQ*WIDTH-1:0] i_req_a;
  logic [N_REQ*WIDTH-1:0] i_req_b;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [ID_W-1:0]        o_rsp_id;
  logic [WIDTH-1:0]       o_rsp_data;
  logic                   o_busy;
  logic                   o_mul_rst;
  logic                   o_mul_load;
  logic [WIDTH-1:0]       o_mul_a;
  logic [WIDTH-1:0]       o_mul_b;
  logic [WIDTH-1:0]       i_mul_res;

  // Scheduler side.
  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_rsp_ready, i_mul_res,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy,
           o_mul_rst, o_mul_load, o_mul_a, o_mul_b
  );

  // Client / multiplier side.
  modport master (
    output i_req_valid, i_req_a, i_req_b, i_rsp_ready, i_mul_res,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy,
           o_mul_rst, o_mul_load, o_mul_a, o_mul_b
  );

endinterface

// File: rtl/fp_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_id_o,
  output logic             any_req_o
);

  logic found;

  // Two passes: indices from ptr_i upward first, then the wrapped low indices.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    any_req_o  = |req_i;
    for (int j = 0; j < N_REQ; j++) begin
      if (en_i && !found && req_i[j] && (j >= int'(ptr_i))) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        grant_id_o = ID_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (en_i && !found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        grant_id_o = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one iterative FP multiplier among N_REQ clients.
// Hides the multiplier's clear/load/compute sequence behind request/response handshakes.
module fp_mul_sched
  import fp_mul_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 32,
  parameter int ID_W        = 2,
  parameter int LOAD_CYCLES = 2,
  parameter int CALC_CYCLES = 36
) (
  input logic           i_clk,
  input logic           i_rst,
  fp_mul_sched_if.slave bus
);

  localparam int CNT_W = cnt_width((LOAD_CYCLES > CALC_CYCLES) ? LOAD_CYCLES : CALC_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic              any_req;
  logic              arb_en;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              mul_rst, mul_load, rsp_valid;

  // Arbitration is only live in IDLE; elsewhere requests are ignored.
  assign arb_en = (state_q == IDLE);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i      (bus.i_req_valid),
    .ptr_i      (rr_ptr_q),
    .en_i       (arb_en),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .any_req_o  (any_req)
  );

  // Select the granted requester's operand pair from the packed buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_a = bus.i_req_a[k*WIDTH +: WIDTH];
        sel_b = bus.i_req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state, counter and datapath updates plus the multiplier controls.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    mul_rst    = 1'b1;
    mul_load   = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          a_d      = sel_a;
          b_d      = sel_b;
          id_d     = grant_id;
          rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        mul_load = 1'b1;
        cnt_d    = CNT_W'(LOAD_CYCLES - 1);
        state_d  = LOAD;
      end
      LOAD: begin
        mul_rst  = 1'b0;
        mul_load = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(CALC_CYCLES - 1);
          state_d = CALC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CALC: begin
        mul_rst = 1'b0;
        if (cnt_q == '0) begin
          rsp_data_d = bus.i_mul_res;
          rsp_id_d   = id_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (bus.i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the operand and response registers are reset as well, because
      // their reset values are visible on the outputs and an aborted result
      // must not survive a reset.
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // that were present before the edge, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign bus.o_req_ready = grant;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_id    = rsp_id_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_mul_rst   = mul_rst;
  assign bus.o_mul_load  = mul_load;
  assign bus.o_mul_a     = a_q;
  assign bus.o_mul_b     = b_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Self-checking bench for fp_mul_sched with a behavioural iterative multiplier
// and a response scoreboard.
module tb_fp_mul_sched;
  import fp_mul_pkg::*;

  localparam int N_REQ       = 4;
  localparam int WIDTH       = 32;
  localparam int ID_W        = 2;
  localparam int LOAD_CYCLES = 2;
  localparam int CALC_CYCLES = 36;
  localparam int LATENCY     = 1 + LOAD_CYCLES + CALC_CYCLES;
  localparam int MUL_LAT     = 35;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
  } rsp_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  fp_mul_sched_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  fp_mul_sched #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W),
    .LOAD_CYCLES(LOAD_CYCLES), .CALC_CYCLES(CALC_CYCLES)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural multiplier: result valid only MUL_LAT cycles after load drops.
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  int               m_cnt = 0;
  logic             m_loaded = 1'b0;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'hC0000000_3E000000: return 32'hBE800000;
      64'h3F800000_40000000: return 32'h40000000;
      64'h40400000_3F000000: return 32'h3FC00000;
      64'h40600000_425D0000: return 32'h43416000;
      64'hBFC00000_40800000: return 32'hC0C00000;
      64'h4091EB85_7F400000: return POS_INF;
      {POS_INF, QNAN}:       return QNAN;
      {NEG_INF, 32'h40000000}: return NEG_INF;
      64'h40000000_40000000: return 32'h40800000;
      64'h3E000000_41000000: return 32'h3F800000;
      64'h40400000_40400000: return 32'h41100000;
      default:               return 32'h0BADF00D;
    endcase
  endfunction

  always @(posedge i_clk) begin
    if (bus.o_mul_rst) begin
      m_cnt    <= 0;
      m_loaded <= 1'b0;
    end else if (bus.o_mul_load) begin
      m_a      <= bus.o_mul_a;
      m_b      <= bus.o_mul_b;
      m_cnt    <= 0;
      m_loaded <= 1'b1;
    end else if (m_cnt < 1000) begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign bus.i_mul_res = (m_loaded && m_cnt >= MUL_LAT) ? ref_mul(m_a, m_b) : 32'hDEADBEEF;

  // Multiplier bus monitor: records protocol violations and completed load runs.
  int               proto_err = 0;
  int               load_runs = 0;
  int               load_len  = 0;
  logic             prev_rst  = 1'b1;
  logic             prev_busy = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;

  always @(negedge i_clk) begin
    if (i_rst) begin
      load_len  <= 0;
      prev_rst  <= 1'b1;
      prev_busy <= 1'b0;
    end else begin
      if (bus.o_mul_load) begin
        load_len <= load_len + 1;
      end else if (load_len != 0) begin
        load_runs <= load_runs + 1;
        load_len  <= 0;
        if (load_len != 1 + LOAD_CYCLES) proto_err <= proto_err + 1;
      end
      if (prev_rst && !bus.o_mul_rst && !(bus.o_mul_load && load_len == 1))
        proto_err <= proto_err + 1;
      if (!bus.o_busy && !bus.o_mul_rst)
        proto_err <= proto_err + 1;
      if (bus.o_busy && !prev_busy) begin
        op_a <= bus.o_mul_a;
        op_b <= bus.o_mul_b;
      end else if (bus.o_busy && (bus.o_mul_a !== op_a || bus.o_mul_b !== op_b)) begin
        proto_err <= proto_err + 1;
      end
      prev_rst  <= bus.o_mul_rst;
      prev_busy <= bus.o_busy;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
    bus.i_req_a[k*WIDTH +: WIDTH] = a;
    bus.i_req_b[k*WIDTH +: WIDTH] = b;
    bus.i_req_valid[k] = 1'b1;
  endtask

  task automatic drop_req(input int k);
    bus.i_req_valid[k] = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  // Waits (bounded) for any o_req_ready; returns at a point before the accept edge.
  task automatic wait_grant(output logic [N_REQ-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.o_req_ready != '0) begin
        g  = bus.o_req_ready;
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Counts edges (bounded) from the accept edge until o_rsp_valid is seen.
  task automatic wait_rsp(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_rsp_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_rsp_ready = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (bus.o_req_ready === '0 && bus.o_rsp_valid === 1'b0 && bus.o_busy === 1'b0) n_pass++;
    else $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b required 0/0/0",
                  bus.o_req_ready, bus.o_rsp_valid, bus.o_busy);
    n_checks++;
    if (bus.o_rsp_id === '0 && bus.o_rsp_data === '0) n_pass++;
    else $display("FAIL reset_rsp: id=%0d data=%h required 0/00000000", bus.o_rsp_id, bus.o_rsp_data);
    n_checks++;
    if (bus.o_mul_rst === 1'b1 && bus.o_mul_load === 1'b0 && bus.o_mul_a === '0 && bus.o_mul_b === '0) n_pass++;
    else $display("FAIL reset_mul: rst=%b load=%b a=%h b=%h required 1/0/0/0",
                  bus.o_mul_rst, bus.o_mul_load, bus.o_mul_a, bus.o_mul_b);
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] g;
    bit ok;
    int lat;
    rsp_t exp;
    set_req(0, 32'hC0000000, 32'h3E000000);
    wait_grant(g, ok);
    n_checks++;
    if (ok && g === 4'b0001) n_pass++;
    else $display("FAIL single_grant: ready=%b required 0001", g);
    sb.push_back('{id: ID_W'(0), data: 32'hBE800000});
    tick();
    drop_req(0);
    wait_rsp(lat, ok);
    n_checks++;
    if (ok && lat == LATENCY) n_pass++;
    else $display("FAIL single_latency: got %0d cycles required %0d", lat, LATENCY);
    exp = sb.pop_front();
    n_checks++;
    if (bus.o_rsp_data === exp.data && bus.o_rsp_id === exp.id) n_pass++;
    else $display("FAIL single_rsp: id=%0d data=%h required id=%0d data=%h",
                  bus.o_rsp_id, bus.o_rsp_data, exp.id, exp.data);
    tick();
    n_checks++;
    if (bus.o_rsp_valid === 1'b0 && bus.o_busy === 1'b0) n_pass++;
    else $display("FAIL single_one_cycle: rsp_valid=%b busy=%b required 0/0", bus.o_rsp_valid, bus.o_busy);
  endtask

  task automatic test_contention();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vp [4];
    logic [N_REQ-1:0] g, e;
    bit ok;
    int lat;
    rsp_t exp;
    va = '{32'h3F800000, 32'h40400000, 32'h40600000, 32'hBFC00000};
    vb = '{32'h40000000, 32'h3F000000, 32'h425D0000, 32'h40800000};
    vp = '{32'h40000000, 32'h3FC00000, 32'h43416000, 32'hC0C00000};
    for (int t = 0; t < N_REQ; t++) set_req(t, va[t], vb[t]);
    for (int t = 0; t < N_REQ; t++) begin
      e = N_REQ'(1) << t;
      wait_grant(g, ok);
      n_checks++;
      if (ok && g === e) n_pass++;
      else $display("FAIL contention_grant%0d: ready=%b required %b", t, g, e);
      sb.push_back('{id: ID_W'(t), data: vp[t]});
      tick();
      drop_req(t);
      n_checks++;
      if (bus.o_req_ready === '0) n_pass++;
      else $display("FAIL contention_ready_pulse%0d: ready=%b required 0000", t, bus.o_req_ready);
      wait_rsp(lat, ok);
      exp = sb.pop_front();
      n_checks++;
      if (ok && bus.o_rsp_data === exp.data && bus.o_rsp_id === exp.id) n_pass++;
      else $display("FAIL contention_rsp%0d: id=%0d data=%h required id=%0d data=%h",
                    t, bus.o_rsp_id, bus.o_rsp_data, exp.id, exp.data);
      tick();
    end
  endtask

  task automatic test_overflow_nan();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vp [3];
    logic [N_REQ-1:0] g, e;
    bit ok;
    int lat;
    rsp_t exp;
    va = '{32'h4091EB85, POS_INF, NEG_INF};
    vb = '{32'h7F400000, QNAN, 32'h40000000};
    vp = '{POS_INF, QNAN, NEG_INF};
    for (int t = 0; t < 3; t++) begin
      set_req(t, va[t], vb[t]);
      e = N_REQ'(1) << t;
      wait_grant(g, ok);
      n_checks++;
      if (ok && g === e) n_pass++;
      else $display("FAIL special_grant%0d: ready=%b required %b", t, g, e);
      sb.push_back('{id: ID_W'(t), data: vp[t]});
      tick();
      drop_req(t);
      wait_rsp(lat, ok);
      exp = sb.pop_front();
      n_checks++;
      if (ok && bus.o_rsp_data === exp.data && bus.o_rsp_id === exp.id) n_pass++;
      else $display("FAIL special_rsp%0d: id=%0d data=%h required id=%0d data=%h",
                    t, bus.o_rsp_id, bus.o_rsp_data, exp.id, exp.data);
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [N_REQ-1:0] g;
    logic [WIDTH-1:0] d0;
    logic [ID_W-1:0]  i0;
    bit ok, stable, quiet;
    int lat;
    rsp_t exp;
    set_req(2, 32'h40000000, 32'h40000000);
    bus.i_rsp_ready = 1'b0;
    wait_grant(g, ok);
    n_checks++;
    if (ok && g === 4'b0100) n_pass++;
    else $display("FAIL bp_grant: ready=%b required 0100", g);
    sb.push_back('{id: ID_W'(2), data: 32'h40800000});
    tick();
    drop_req(2);
    set_req(3, 32'h3E000000, 32'h41000000);
    wait_rsp(lat, ok);
    d0 = bus.o_rsp_data;
    i0 = bus.o_rsp_id;
    stable = ok;
    quiet  = 1'b1;
    repeat (20) begin
      tick();
      if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== d0 || bus.o_rsp_id !== i0) stable = 1'b0;
      if (bus.o_req_ready !== '0) quiet = 1'b0;
    end
    n_checks++;
    if (stable) n_pass++;
    else $display("FAIL bp_stable: valid=%b data=%h id=%0d drifted from data=%h id=%0d",
                  bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_id, d0, i0);
    n_checks++;
    if (quiet) n_pass++;
    else $display("FAIL bp_no_accept: ready=%b required 0000 during stall", bus.o_req_ready);
    exp = sb.pop_front();
    n_checks++;
    if (d0 === exp.data && i0 === exp.id) n_pass++;
    else $display("FAIL bp_rsp: id=%0d data=%h required id=%0d data=%h", i0, d0, exp.id, exp.data);
    bus.i_rsp_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (bus.o_rsp_valid === 1'b0 && bus.o_req_ready === 4'b1000) n_pass++;
    else $display("FAIL bp_release: rsp_valid=%b ready=%b required 0/1000", bus.o_rsp_valid, bus.o_req_ready);
    sb.push_back('{id: ID_W'(3), data: 32'h3F800000});
    tick();
    drop_req(3);
    wait_rsp(lat, ok);
    exp = sb.pop_front();
    n_checks++;
    if (ok && lat == LATENCY && bus.o_rsp_data === exp.data && bus.o_rsp_id === exp.id) n_pass++;
    else $display("FAIL bp_next_rsp: lat=%0d id=%0d data=%h required lat=%0d id=%0d data=%h",
                  lat, bus.o_rsp_id, bus.o_rsp_data, LATENCY, exp.id, exp.data);
    tick();
  endtask

  task automatic test_reset_mid_calc();
    logic [N_REQ-1:0] g;
    bit ok, quiet;
    int lat;
    rsp_t exp;
    set_req(1, 32'h3F800000, 32'h3F800000);
    wait_grant(g, ok);
    n_checks++;
    if (ok && g === 4'b0010) n_pass++;
    else $display("FAIL rst_first_grant: ready=%b required 0010", g);
    tick();
    drop_req(1);
    set_req(3, 32'h40400000, 32'h40400000);
    repeat (2) tick();
    set_req(2, 32'h40000000, 32'h40000000);
    repeat (3) tick();
    drop_req(2);
    repeat (7) tick();
    n_checks++;
    if (bus.o_busy === 1'b1 && bus.o_mul_rst === 1'b0 && bus.o_mul_load === 1'b0) n_pass++;
    else $display("FAIL rst_in_calc: busy=%b mul_rst=%b mul_load=%b required 1/0/0",
                  bus.o_busy, bus.o_mul_rst, bus.o_mul_load);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (bus.o_busy === 1'b0 && bus.o_mul_rst === 1'b1 && bus.o_rsp_valid === 1'b0) n_pass++;
    else $display("FAIL rst_abort_ctrl: busy=%b mul_rst=%b rsp_valid=%b required 0/1/0",
                  bus.o_busy, bus.o_mul_rst, bus.o_rsp_valid);
    n_checks++;
    if (bus.o_mul_a === '0 && bus.o_mul_b === '0 && bus.o_rsp_data === '0 && bus.o_rsp_id === '0) n_pass++;
    else $display("FAIL rst_abort_regs: a=%h b=%h data=%h id=%0d required all zero",
                  bus.o_mul_a, bus.o_mul_b, bus.o_rsp_data, bus.o_rsp_id);
    wait_grant(g, ok);
    n_checks++;
    if (ok && g === 4'b1000) n_pass++;
    else $display("FAIL rst_pending_grant: ready=%b required 1000", g);
    sb.push_back('{id: ID_W'(3), data: 32'h41100000});
    tick();
    drop_req(3);
    wait_rsp(lat, ok);
    exp = sb.pop_front();
    n_checks++;
    if (ok && lat == LATENCY && bus.o_rsp_data === exp.data && bus.o_rsp_id === exp.id) n_pass++;
    else $display("FAIL rst_pending_rsp: lat=%0d id=%0d data=%h required lat=%0d id=%0d data=%h",
                  lat, bus.o_rsp_id, bus.o_rsp_data, LATENCY, exp.id, exp.data);
    tick();
    quiet = 1'b1;
    repeat (5) begin
      if (bus.o_req_ready !== '0 || bus.o_busy !== 1'b0) quiet = 1'b0;
      tick();
    end
    n_checks++;
    if (quiet) n_pass++;
    else $display("FAIL rst_dropped_req_served: ready=%b busy=%b required idle", bus.o_req_ready, bus.o_busy);
  endtask

  task automatic test_protocol();
    n_checks++;
    if (proto_err == 0) n_pass++;
    else $display("FAIL mul_protocol: %0d violations required 0", proto_err);
    n_checks++;
    if (load_runs == 12) n_pass++;
    else $display("FAIL mul_load_runs: got %0d required 12", load_runs);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
  endtask

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_contention();
    test_overflow_nan();
    test_backpressure();
    test_reset_mid_calc();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
